// File: rtl/led_pwm_pkg.sv
// Shared constants for the led_pwm_ctrl register block: word offsets, CTRL bit layout,
// read latency and the address decoder used by the top level.
package led_pwm_pkg;

    localparam int unsigned CTRL_ADDR    = 0;
    localparam int unsigned ON_ADDR      = 1;
    localparam int unsigned BLINK_ADDR   = 2;
    localparam int unsigned PERIOD_ADDR  = 3;
    localparam int unsigned DUTY_BASE    = 4;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned READ_LATENCY = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_ON,
        SEL_BLINK,
        SEL_PERIOD,
        SEL_DUTY
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input int unsigned addr, input int unsigned num_leds);
        if (addr == CTRL_ADDR)   return SEL_CTRL;
        if (addr == ON_ADDR)     return SEL_ON;
        if (addr == BLINK_ADDR)  return SEL_BLINK;
        if (addr == PERIOD_ADDR) return SEL_PERIOD;
        if (addr >= DUTY_BASE && addr < DUTY_BASE + num_leds) return SEL_DUTY;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: duty shadow register, PWM comparator and registered output.
// With LED_PWM_FADE_EN defined the shadow steps by one toward the target on each wrap.
module led_pwm_channel #(
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wrap,
    input  logic                enable,
    input  logic                on_mask,
    input  logic                blink_mask,
    input  logic                phase,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    input  logic [PWM_BITS-1:0] duty,
    output logic                led
);

    logic [PWM_BITS-1:0] active_duty;
    logic                on;

    // The shadow only moves at a period boundary so a period never mixes two duties.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_duty <= '0;
        end else if (wrap) begin
`ifdef LED_PWM_FADE_EN
            if (active_duty < duty)
                active_duty <= active_duty + 1'b1;
            else if (active_duty > duty)
                active_duty <= active_duty - 1'b1;
`else
            active_duty <= duty;
`endif
        end
    end

    always_comb begin
        on = enable & on_mask
           & ((&active_duty) | (pwm_cnt < active_duty))
           & (~blink_mask | phase);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            led <= 1'b0;
        else
            led <= on;
    end

endmodule

// File: rtl/led_pwm_ctrl.sv
// Avalon-MM LED controller: register file, prescaler, shared PWM counter and blink timer,
// feeding one led_pwm_channel per LED. Optional duty fading is enabled by LED_PWM_FADE_EN.
module led_pwm_ctrl
    import led_pwm_pkg::*;
#(
    parameter  int unsigned NUM_LEDS   = 8,
    parameter  int unsigned PWM_BITS   = 8,
    parameter  int unsigned PRESCALE   = 195,
    parameter  int unsigned BLINK_BITS = 16,
    localparam int unsigned ADDR_W     = $clog2(4 + NUM_LEDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    output logic [31:0]       avs_readdata,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    output logic [NUM_LEDS-1:0] leds
);

    localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic                  ctrl_en;
    logic [NUM_LEDS-1:0]   on_mask;
    logic [NUM_LEDS-1:0]   blink_mask;
    logic [BLINK_BITS-1:0] blink_period;
    logic [PWM_BITS-1:0]   duty [NUM_LEDS];

    logic [PS_W-1:0]       presc_cnt;
    logic [PWM_BITS-1:0]   pwm_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic                  phase;
    logic                  tick;
    logic                  wrap;

    reg_sel_e              sel;
    logic                  wr_ctrl, wr_on, wr_blink, wr_period;
    logic [NUM_LEDS-1:0]   wr_duty;
    logic [31:0]           read_value;
    logic                  unused_wdata;

    assign unused_wdata = ^avs_writedata;

    always_comb begin
        sel       = decode_addr(32'(avs_address), NUM_LEDS);
        wr_ctrl   = avs_write && (sel == SEL_CTRL);
        wr_on     = avs_write && (sel == SEL_ON);
        wr_blink  = avs_write && (sel == SEL_BLINK);
        wr_period = avs_write && (sel == SEL_PERIOD);
        for (int unsigned i = 0; i < NUM_LEDS; i++)
            wr_duty[i] = avs_write && (avs_address == ADDR_W'(DUTY_BASE + i));
    end

    always_comb begin
        read_value = '0;
        case (sel)
            SEL_CTRL:   read_value[CTRL_EN_BIT] = ctrl_en;
            SEL_ON:     read_value = 32'(on_mask);
            SEL_BLINK:  read_value = 32'(blink_mask);
            SEL_PERIOD: read_value = 32'(blink_period);
            SEL_DUTY: begin
                for (int unsigned i = 0; i < NUM_LEDS; i++)
                    if (avs_address == ADDR_W'(DUTY_BASE + i))
                        read_value = 32'(duty[i]);
            end
            default:    read_value = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en      <= 1'b0;
            on_mask      <= '0;
            blink_mask   <= '0;
            blink_period <= '0;
            for (int unsigned i = 0; i < NUM_LEDS; i++)
                duty[i] <= '0;
        end else begin
            if (wr_ctrl)   ctrl_en      <= avs_writedata[CTRL_EN_BIT];
            if (wr_on)     on_mask      <= avs_writedata[NUM_LEDS-1:0];
            if (wr_blink)  blink_mask   <= avs_writedata[NUM_LEDS-1:0];
            if (wr_period) blink_period <= avs_writedata[BLINK_BITS-1:0];
            for (int unsigned i = 0; i < NUM_LEDS; i++)
                if (wr_duty[i]) duty[i] <= avs_writedata[PWM_BITS-1:0];
        end
    end

    // read_value is taken from the pre-edge registers, so a same-cycle write reads back old data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= read_value;
    end

    assign tick = (presc_cnt == PS_W'(PRESCALE - 1));
    assign wrap = tick & (&pwm_cnt);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_cnt <= '0;
            pwm_cnt   <= '0;
        end else begin
            presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
            if (tick) pwm_cnt <= pwm_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (wr_period || blink_period == '0) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (wrap) begin
            if (blink_cnt == blink_period - 1'b1) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_ch
        led_pwm_channel #(
            .PWM_BITS(PWM_BITS)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .wrap       (wrap),
            .enable     (ctrl_en),
            .on_mask    (on_mask[g]),
            .blink_mask (blink_mask[g]),
            .phase      (phase),
            .pwm_cnt    (pwm_cnt),
            .duty       (duty[g]),
            .led        (leds[g])
        );
    end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl: cycle-time arithmetic reference model compared every
// cycle, plus directed literal checks. Fade-specific checks compile under LED_PWM_FADE_EN.
module tb_led_pwm_ctrl;

    localparam int unsigned NL   = 8;
    localparam int unsigned PB   = 8;
    localparam int unsigned PS   = 1;
    localparam int unsigned BB   = 16;
    localparam int unsigned AW   = $clog2(4 + NL);
    localparam int unsigned PMAX = (1 << PB) - 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] avs_address;
    logic          avs_read;
    logic [31:0]   avs_readdata;
    logic          avs_write;
    logic [31:0]   avs_writedata;
    logic [NL-1:0] leds;

    always #5 clk = ~clk;

    led_pwm_ctrl #(
        .NUM_LEDS   (NL),
        .PWM_BITS   (PB),
        .PRESCALE   (PS),
        .BLINK_BITS (BB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_readdata  (avs_readdata),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .leds          (leds)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: time since reset gives the PWM position; wraps since the last
    // BLINK_PERIOD write give the blink phase.
    int unsigned   m_t;
    int unsigned   m_wraps;
    logic          m_ctrl;
    logic [NL-1:0] m_on;
    logic [NL-1:0] m_blink;
    int unsigned   m_period;
    int unsigned   m_duty   [NL];
    int unsigned   m_active [NL];
    logic [NL-1:0] m_leds;
    logic [31:0]   m_rdata;

    function automatic int unsigned model_pwm();
        return (m_t / PS) % (PMAX + 1);
    endfunction

    function automatic bit model_wrap();
        return ((m_t % PS) == PS - 1) && (model_pwm() == PMAX);
    endfunction

    function automatic bit model_phase();
        if (m_period == 0) return 1'b1;
        return ((m_wraps / m_period) % 2) == 0;
    endfunction

    function automatic bit model_on(input int i);
        return m_ctrl && m_on[i]
            && (m_active[i] == PMAX || model_pwm() < m_active[i])
            && (!m_blink[i] || model_phase());
    endfunction

    function automatic logic [31:0] model_read(input int unsigned a);
        if (a == 0) return {31'b0, m_ctrl};
        if (a == 1) return 32'(m_on);
        if (a == 2) return 32'(m_blink);
        if (a == 3) return m_period;
        if (a >= 4 && a < 4 + NL) return m_duty[a - 4];
        return 32'd0;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t      <= 0;
            m_wraps  <= 0;
            m_ctrl   <= 1'b0;
            m_on     <= '0;
            m_blink  <= '0;
            m_period <= 0;
            m_leds   <= '0;
            m_rdata  <= '0;
            for (int i = 0; i < NL; i++) begin
                m_duty[i]   <= 0;
                m_active[i] <= 0;
            end
        end else begin
            for (int i = 0; i < NL; i++) m_leds[i] <= model_on(i);
            m_t <= m_t + 1;
            if (avs_read) m_rdata <= model_read(32'(avs_address));
            if (avs_write) begin
                if (avs_address == 0) m_ctrl <= avs_writedata[0];
                else if (avs_address == 1) m_on <= avs_writedata[NL-1:0];
                else if (avs_address == 2) m_blink <= avs_writedata[NL-1:0];
                else if (avs_address == 3) m_period <= 32'(avs_writedata[BB-1:0]);
                else if (32'(avs_address) < 4 + NL)
                    m_duty[32'(avs_address) - 4] <= 32'(avs_writedata[PB-1:0]);
            end
            if (avs_write && avs_address == 3) m_wraps <= 0;
            else if (model_wrap()) m_wraps <= m_wraps + 1;
            if (model_wrap()) begin
                for (int i = 0; i < NL; i++) begin
`ifdef LED_PWM_FADE_EN
                    if (m_active[i] < m_duty[i]) m_active[i] <= m_active[i] + 1;
                    else if (m_active[i] > m_duty[i]) m_active[i] <= m_active[i] - 1;
`else
                    m_active[i] <= m_duty[i];
`endif
                end
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (leds !== m_leds) begin
            n_fail++;
            $display("FAIL leds @%0t: got %h expected %h", $time, leds, m_leds);
        end
        n_checks++;
        if (avs_readdata !== m_rdata) begin
            n_fail++;
            $display("FAIL readdata @%0t: got %h expected %h", $time, avs_readdata, m_rdata);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wr(input int unsigned a, input logic [31:0] d);
        avs_address   = AW'(a);
        avs_writedata = d;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic rd(input int unsigned a, output logic [31:0] d);
        avs_address = AW'(a);
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        d = avs_readdata;
    endtask

    task automatic count_hi(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            c += int'(leds[0]);
        end
    endtask

    logic [31:0] rv;
    int          c1, c2, k;
    int unsigned op, a;
    logic [31:0] d;

    initial begin
        reset = 1'b1;
        avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        wr(0, 1); wr(1, 1); wr(4, 255);
        rd(1, rv);
        check("pre_reset_read_on", rv, 1);
        repeat (300) @(negedge clk);
`ifndef LED_PWM_FADE_EN
        check("pre_reset_led", 32'(leds[0]), 1);
`endif
        #2 reset = 1'b1;
        #1;
        check("reset_leds", 32'(leds), 0);
        check("reset_readdata", avs_readdata, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        rd(0, rv); check("reset_ctrl", rv, 0);
        rd(1, rv); check("reset_on", rv, 0);
        rd(4, rv); check("reset_duty0", rv, 0);

`ifndef LED_PWM_FADE_EN
        wr(0, 1); wr(1, 1); wr(4, 64);
        repeat (300) @(negedge clk);
        count_hi(256, c1); check("duty64", c1, 64);

        k = 0;
        while (model_pwm() != 10 && k < 600) begin @(negedge clk); k++; end
        if (k >= 600) begin
            n_checks++; n_fail++;
            $display("FAIL shadow_align: got timeout expected pwm position 10");
        end
        avs_address = AW'(4); avs_writedata = 200; avs_write = 1'b1;
        @(negedge clk);
        avs_write = 1'b0;
        c1 = int'(leds[0]);
        count_hi(245, c2);
        check("shadow_old_period", c1 + c2, 54);
        count_hi(256, c1); check("shadow_new_period", c1, 200);

        wr(4, 255); repeat (300) @(negedge clk);
        count_hi(256, c1); check("duty255", c1, 256);
        wr(4, 0); repeat (300) @(negedge clk);
        count_hi(256, c1); check("duty0", c1, 0);

        wr(4, 255); repeat (300) @(negedge clk);
        wr(2, 1); wr(3, 2);
        count_hi(1024, c1); check("blink_p2", c1, 512);
        wr(3, 0);
        count_hi(1024, c1); check("blink_p0", c1, 1024);
`else
        wr(0, 1); wr(1, 1); wr(4, 8);
        repeat (9 * 256) @(negedge clk);
        count_hi(256, c1); check("fade_up", c1, 8);
        wr(4, 0);
        repeat (9 * 256) @(negedge clk);
        count_hi(256, c1); check("fade_down", c1, 0);
`endif

        wr(1, 1);
        wr(4 + NL, 32'hFFFF_FFFF);
        rd(4 + NL, rv); check("oob_read", rv, 0);
        rd(1, rv); check("oob_write_on", rv, 1);
        rd(0, rv); check("oob_write_ctrl", rv, 1);
        avs_address = AW'(1); avs_writedata = 32'h5A; avs_write = 1'b1; avs_read = 1'b1;
        @(negedge clk);
        avs_write = 1'b0; avs_read = 1'b0;
        check("rw_same_old", avs_readdata, 1);
        rd(1, rv); check("rw_same_new", rv, 32'h5A);
        wr(1, 32'hFFFF_FFFF);
        rd(1, rv); check("on_mask_width", rv, 32'hFF);

        for (int i = 0; i < 6000; i++) begin
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 15);
            d  = $urandom;
            if (a == 3) begin
                if ($urandom_range(0, 19) != 0) op = 2;
                d = $urandom_range(0, 3);
            end
            avs_address   = AW'(a);
            avs_writedata = d;
            avs_write     = op[0];
            avs_read      = op[1];
            @(negedge clk);
        end
        avs_write = 1'b0;
        avs_read  = 1'b0;
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
Avalon-MM slave LED controller with NUM_LEDS channels, each with independent PWM brightness and blink gating. It is the parametrised successor to the fixed 8-bit custom LED register block and sits on the HPS lightweight bridge. It drives the board LED pins from registered outputs.

Parameters:
NUM_LEDS, 8, number of LED channels (1..28).
PWM_BITS, 8, PWM counter and duty width (4..16).
PRESCALE, 195, clk cycles per PWM counter step (>=1).
BLINK_BITS, 16, blink period register width, in PWM periods.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous active-high reset.
avs_address  in  ADDR_W  word address; ADDR_W = clog2(4+NUM_LEDS), a localparam.
avs_read  in  1  read strobe.
avs_readdata  out  32  read data, fixed latency 1.
avs_write  in  1  write strobe.
avs_writedata  in  32  write data.
leds  out  NUM_LEDS  LED drive, active-high, registered.

Behaviour:
- Reset: leds=0, avs_readdata=0, all registers 0, all counters 0, blink phase=1.
- Register map (word address):
  - 0 CTRL: bit0 global enable.
  - 1 ON_MASK.
  - 2 BLINK_MASK.
  - 3 BLINK_PERIOD.
  - 4+i DUTY[i].
  - Unused upper bits are ignored on write and read as 0.
- Writes take effect the cycle after avs_write. Addresses >= 4+NUM_LEDS: write ignored, read returns 0.
- Reads: avs_readdata is registered one cycle after avs_read and holds its value otherwise. A simultaneous read and write to the same address returns the pre-write value.
- Prescaler: counts 0..PRESCALE-1; tick=1 when count==PRESCALE-1, then wraps to 0.
- PWM counter: PWM_BITS wide, increments on tick, wraps from all-ones to 0. wrap = tick while pwm_cnt is all-ones.
- Duty shadow: DUTY[i] is copied into active_duty[i] only on wrap, so there are no mid-period glitches.
- Channel on condition: on_i = CTRL[0] & ON_MASK[i] & (active_duty[i]==all-ones | pwm_cnt < active_duty[i]) & (~BLINK_MASK[i] | phase).
  - duty 0 is fully off; all-ones is fully on.
- Blink: blink_cnt increments on wrap. When blink_cnt == BLINK_PERIOD-1 on a wrap, phase toggles and blink_cnt clears. BLINK_PERIOD==0 holds phase=1 and blink_cnt=0.
- A write to BLINK_PERIOD clears blink_cnt and sets phase=1.
- leds[i] is registered from on_i: one cycle of output latency.
- Clearing CTRL[0]: leds go to 0 the next cycle; counters keep running.
- Reset asserted mid-period: all state returns to reset values immediately (asynchronous).

Optional Feature:
Macro LED_PWM_FADE_EN.
- Defined: on each wrap, active_duty[i] steps by ±1 toward DUTY[i] instead of being copied directly. A full 0->255 ramp at PWM_BITS=8 takes 255 PWM periods.
- Undefined: direct copy on wrap, as above.
- Register map and readback are identical in both builds; DUTY reads the target value, not active_duty.

Decomposition:
- Package led_pwm_pkg holds:
  - register offset constants (CTRL_ADDR=0, ON_ADDR=1, BLINK_ADDR=2, PERIOD_ADDR=3, DUTY_BASE=4);
  - the CTRL enable bit index;
  - the read-latency constant (1).
- Sub-module led_pwm_channel, one instance per channel via generate: holds active_duty (with the fade stepper under the macro), the comparator and the output register.
- Prescaler, PWM counter, blink logic and register file stay in the top module.

Test Plan:
- Reset: assert reset mid-run -> leds=0 and avs_readdata=0 immediately; read of CTRL, ON_MASK and DUTY[0] after release returns 0.
- PWM duty: PRESCALE=1, PWM_BITS=8, CTRL=1, ON_MASK=0x01, DUTY[0]=64 -> leds[0] high exactly 64 of each 256 cycles. DUTY=255 -> constant high. DUTY=0 -> constant low.
- Shadow update: write DUTY[0]=200 while pwm_cnt=10 -> high time changes only from the next wrap; the current period still uses the old duty.
- Blink: BLINK_PERIOD=2, BLINK_MASK=0x01, DUTY[0]=255 -> leds[0] alternates 2 PWM periods on, 2 off. BLINK_PERIOD=0 -> steady on.
- Bus edges:
  - read of address 4+NUM_LEDS returns 0 and a write there changes nothing;
  - same-cycle read and write of ON_MASK returns the old value, and the next read returns the new value;
  - writing 0xFFFFFFFF to ON_MASK reads back with only NUM_LEDS bits set.
- LED_PWM_FADE_EN build: DUTY[0] 0->8 -> active duty reaches 8 after exactly 8 wraps. DUTY then written 8->0 -> ramps back down in 8 wraps.
